// File: rtl/hdlc_receiver.sv
// HDLC receive path: RX synchronizer, bit timing, zero destuffing, flag/abort detection,
// LSB-first byte assembly and a first-word-fall-through receive FIFO with sticky status.
module hdlc_receiver #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          RX,
  input  logic [7:0]    BAUD,
  input  logic          EN,
  input  logic          RD,
  input  logic          CLR,
  output logic [7:0]    DOUT,
  output logic          RXEMPTY,
  output logic          RXFULL,
  output logic [CW-1:0] COUNT,
  output logic          OVERRUN,
  output logic          FRAMEERR,
  output logic          ABORT,
  output logic          FRAMEDONE
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned TW  = 8;
  localparam int unsigned DLW = 6;

  typedef enum logic {HUNT = 1'b0, OPEN = 1'b1} state_t;

  state_t         state, state_n;
  logic           sync1, sync2, rx_prev;
  logic [TW-1:0]  timer, timer_n, period_c, half_c;
  logic           rx_edge_c, sample_c;
  logic [2:0]     ones, ones_n;
  logic           push_c, flag_c, abort_c;
  logic [DLW-1:0] dl, dl_n;
  logic [2:0]     dl_cnt, dl_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic           got_byte, got_byte_n;
  logic           wr_pend, wr_pend_n;
  logic [7:0]     wr_data, wr_data_n;
  logic           clear_c, done_c, set_ferr_c, set_abort_c;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]  count_n;
  logic [7:0]     dout_n;
  logic           do_rd_c, wr_ok_c, set_ovr_c, head_new_c;

  // Bit timing: timer realigns on every line edge, samples at mid-bit
  always_comb begin
    period_c  = (BAUD < 8'd3) ? 8'd3 : BAUD;
    half_c    = period_c >> 1;
    rx_edge_c = sync2 ^ rx_prev;
    sample_c  = EN && (timer == half_c);
    timer_n   = timer + TW'(1);
    if (!EN || rx_edge_c || (timer == period_c)) timer_n = '0;
  end

  // Destuffer: classifies each sample as data push, stuffed zero, flag or abort
  always_comb begin
    ones_n  = ones;
    push_c  = 1'b0;
    flag_c  = 1'b0;
    abort_c = 1'b0;
    if (!EN) begin
      ones_n = '0;
    end else if (sample_c) begin
      if (ones < 3'd5) begin
        push_c = 1'b1;
        ones_n = sync2 ? ones + 3'd1 : 3'd0;
      end else if (ones == 3'd5) begin
        ones_n = sync2 ? 3'd6 : 3'd0;
      end else if (sync2) begin
        abort_c = 1'b1;
      end else begin
        flag_c = 1'b1;
        ones_n = '0;
      end
    end
  end

  // Framing: the 6-bit delay line hides the closing flag's leading 0 and five 1s
  always_comb begin
    state_n     = state;
    dl_n        = dl;
    dl_cnt_n    = dl_cnt;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    got_byte_n  = got_byte;
    wr_pend_n   = 1'b0;
    wr_data_n   = wr_data;
    clear_c     = 1'b0;
    done_c      = 1'b0;
    set_ferr_c  = 1'b0;
    set_abort_c = 1'b0;
    if (!EN) begin
      state_n = HUNT;
      clear_c = 1'b1;
    end else if (state == HUNT) begin
      if (flag_c) begin
        state_n = OPEN;
        clear_c = 1'b1;
      end
    end else if (abort_c) begin
      set_abort_c = 1'b1;
      state_n     = HUNT;
      clear_c     = 1'b1;
    end else if (flag_c) begin
      if (bit_cnt != 3'd0) set_ferr_c = 1'b1;
      else if (got_byte)   done_c     = 1'b1;
      clear_c = 1'b1;
    end else if (push_c) begin
      dl_n = {sync2, dl[DLW-1:1]};
      if (dl_cnt != 3'(DLW)) begin
        dl_cnt_n = dl_cnt + 3'd1;
      end else if (bit_cnt == 3'd7) begin
        wr_pend_n  = 1'b1;
        wr_data_n  = {dl[0], shreg[7:1]};
        bit_cnt_n  = '0;
        got_byte_n = 1'b1;
      end else begin
        shreg_n   = {dl[0], shreg[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
      end
    end
    if (clear_c) begin
      dl_n       = '0;
      dl_cnt_n   = '0;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      got_byte_n = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      timer    <= '0;
      ones     <= '0;
      state    <= HUNT;
      dl       <= '0;
      dl_cnt   <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      got_byte <= 1'b0;
      wr_pend  <= 1'b0;
      wr_data  <= '0;
    end else begin
      sync1    <= RX;
      sync2    <= sync1;
      rx_prev  <= sync2;
      timer    <= timer_n;
      ones     <= ones_n;
      state    <= state_n;
      dl       <= dl_n;
      dl_cnt   <= dl_cnt_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      got_byte <= got_byte_n;
      wr_pend  <= wr_pend_n;
      wr_data  <= wr_data_n;
    end
  end

  // FIFO control; DOUT is registered with the head the FIFO will present next cycle
  always_comb begin
    do_rd_c    = RD && !RXEMPTY;
    wr_ok_c    = wr_pend && (!RXFULL || do_rd_c);
    set_ovr_c  = wr_pend && RXFULL && !do_rd_c;
    count_n    = COUNT + CW'(wr_ok_c) - CW'(do_rd_c);
    rd_ptr_n   = rd_ptr + AW'(do_rd_c);
    head_new_c = wr_ok_c && (COUNT == CW'(do_rd_c));
    dout_n     = mem[rd_ptr_n];
    if (count_n == '0) dout_n = '0;
    else if (head_new_c) dout_n = wr_data;
  end

  always_ff @(posedge CLK) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      RXEMPTY   <= 1'b1;
      RXFULL    <= 1'b0;
      DOUT      <= '0;
      OVERRUN   <= 1'b0;
      FRAMEERR  <= 1'b0;
      ABORT     <= 1'b0;
      FRAMEDONE <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(wr_ok_c);
      rd_ptr    <= rd_ptr_n;
      COUNT     <= count_n;
      RXEMPTY   <= (count_n == '0);
      RXFULL    <= (count_n == CW'(DEPTH));
      DOUT      <= dout_n;
      OVERRUN   <= set_ovr_c   | (OVERRUN  & ~CLR);
      FRAMEERR  <= set_ferr_c  | (FRAMEERR & ~CLR);
      ABORT     <= set_abort_c | (ABORT    & ~CLR);
      FRAMEDONE <= done_c;
    end
  end

endmodule
